sram_host_ctrl: RTL and testbench

Host-side initiator for `sram_top`: accepts parallel read/write requests on a valid/ready port and drives the SRAM's serial write interface (`serial_in`/`shift`), `w_en`, `r_en` and `addr`, then returns a single-cycle response carrying read data from `data_out` when the SRAM raises `data_valid`. It sits between system logic and `sram_top`; one transaction is in flight at a time.

---
 rtl/sram_host_ctrl.sv | 141 ++++++++++++++
 tb/tb_sram_host_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_host_ctrl.sv
// Host-side initiator for sram_top: serialises write data, strobes w_en/r_en and returns one response per request.
// Optional read timeout is enabled by defining SRAM_HOST_TIMEOUT_EN.
module sram_host_ctrl #(
  parameter int ROWS    = 2,
  parameter int COLS    = 1,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [ROWS-1:0] req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [COLS-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            serial_in,
  output logic            shift,
  output logic            w_en,
  output logic            r_en,
  output logic [ROWS-1:0] addr,
  input  logic            data_valid,
  input  logic [COLS-1:0] data_out
);

  localparam int CMAX  = (COLS > TIMEOUT) ? COLS : TIMEOUT;
  localparam int CNT_W = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, WRITE, READ, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [COLS-1:0]  wdata_q;

  // Shared bit/wait counter saturates instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(CMAX)) ? c : c + 1'b1;
  endfunction

`ifndef SRAM_HOST_TIMEOUT_EN
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      serial_in <= 1'b0;
      shift     <= 1'b0;
      w_en      <= 1'b0;
      r_en      <= 1'b0;
      addr      <= '0;
`ifdef SRAM_HOST_TIMEOUT_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them.
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      serial_in <= 1'b0;
      shift     <= 1'b0;
      w_en      <= 1'b0;
      r_en      <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            addr      <= req_addr;
            cnt       <= '0;
            if (req_write) begin
              state     <= SHIFT;
              shift     <= 1'b1;
              serial_in <= req_wdata[COLS-1];
              wdata_q   <= req_wdata << 1;
            end else begin
              state <= READ;
              r_en  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cnt == CNT_W'(COLS - 1)) begin
            state <= WRITE;
            w_en  <= 1'b1;
          end else begin
            cnt       <= cnt_inc(cnt);
            shift     <= 1'b1;
            serial_in <= wdata_q[COLS-1];
            wdata_q   <= wdata_q << 1;
          end
        end
        WRITE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
`ifdef SRAM_HOST_TIMEOUT_EN
          rsp_err   <= 1'b0;
`endif
        end
        READ: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          // Data is checked first so a late data_valid beats the timeout.
          if (data_valid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= data_out;
`ifdef SRAM_HOST_TIMEOUT_EN
            rsp_err   <= 1'b0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
`endif
          end else begin
            cnt <= cnt_inc(cnt);
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          addr      <= '0;
          rsp_rdata <= '0;
`ifdef SRAM_HOST_TIMEOUT_EN
          rsp_err   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_host_ctrl.sv
// Self-checking bench for sram_host_ctrl: per-cycle transaction timing, an SRAM behavioural model and a request-level memory model.
module tb_sram_host_ctrl;
  localparam int ROWS    = 2;
  localparam int COLS    = 4;
  localparam int TIMEOUT = 5;
`ifdef SRAM_HOST_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_write = 1'b0;
  logic [ROWS-1:0] req_addr = '0;
  logic [COLS-1:0] req_wdata = '0;
  logic            rsp_valid;
  logic [COLS-1:0] rsp_rdata;
  logic            rsp_err;
  logic            serial_in;
  logic            shift;
  logic            w_en;
  logic            r_en;
  logic [ROWS-1:0] addr;
  logic            data_valid = 1'b0;
  logic [COLS-1:0] data_out = '0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [COLS-1:0] ref_mem  [2**ROWS];
  logic [COLS-1:0] sram_mem [2**ROWS];
  logic [COLS-1:0] sram_sh;

  sram_host_ctrl #(.ROWS(ROWS), .COLS(COLS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .serial_in(serial_in), .shift(shift), .w_en(w_en), .r_en(r_en),
    .addr(addr), .data_valid(data_valid), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: assembles the serial stream MSB first and stores it on w_en.
  always @(posedge clk) begin
    if (shift) sram_sh = (sram_sh << 1) | COLS'(serial_in);
    if (w_en) sram_mem[addr] = sram_sh;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ROWS-1:0] a, input logic [COLS-1:0] d, input bit hold);
    logic [6:0] obsv, expv;
    bit sb;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_start_ready: got %b, expected 1", req_ready);
    end
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    tick();
    ref_mem[a] = d;
    if (hold) begin
      req_write = 1'($urandom); req_addr = ROWS'($urandom); req_wdata = COLS'($urandom);
    end else begin
      req_valid = 1'b0;
    end
    for (int i = 1; i <= COLS + 3; i++) begin
      if (i > 1) tick();
      sb   = (i <= COLS) ? d[COLS-i] : 1'b0;
      expv = {i == COLS + 3, i == COLS + 2, 1'b0, i <= COLS, sb, i == COLS + 1, 1'b0};
      obsv = {req_ready, rsp_valid, rsp_err, shift, serial_in, w_en, r_en};
      tests_run++;
      if (obsv !== expv || (i <= COLS + 2 && addr !== a) || (rsp_valid === 1'b1 && rsp_rdata !== '0)) begin
        tests_failed++;
        $display("FAIL write_cycle%0d: got rdy/rv/err/sh/si/we/re=%b addr=%0d rdata=%h, expected %b addr=%0d rdata=0",
                 i, obsv, addr, rsp_rdata, expv, a);
      end
    end
  endtask

  // k = cycle in which data_valid is presented (cycle 1 carries r_en); k=0 means never.
  task automatic do_read(input logic [ROWS-1:0] a, input int k, input bit hold);
    logic [6:0] obsv, expv;
    logic [COLS-1:0] val;
    bit err;
    int rc;
    val = ref_mem[a];
    err = TMO_EN && (k == 0 || k > TIMEOUT + 1);
    rc  = err ? TIMEOUT + 2 : k + 1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_start_ready: got %b, expected 1", req_ready);
    end
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = COLS'($urandom);
    tick();
    if (hold) begin
      req_write = 1'($urandom); req_addr = ROWS'($urandom); req_wdata = COLS'($urandom);
    end else begin
      req_valid = 1'b0;
    end
    for (int i = 1; i <= rc + 1; i++) begin
      if (i > 1) tick();
      expv = {i == rc + 1, i == rc, err && i == rc, 1'b0, 1'b0, 1'b0, i == 1};
      obsv = {req_ready, rsp_valid, rsp_err, shift, serial_in, w_en, r_en};
      tests_run++;
      if (obsv !== expv || (i <= rc && addr !== a) || (i == rc && rsp_rdata !== (err ? '0 : val))) begin
        tests_failed++;
        $display("FAIL read_cycle%0d: got rdy/rv/err/sh/si/we/re=%b addr=%0d rdata=%h, expected %b addr=%0d rdata=%h",
                 i, obsv, addr, rsp_rdata, expv, a, err ? '0 : val);
      end
      // Outside WAIT (cycle 1 = READ, cycle rc = RESP) data_valid is noise.
      if (i == k) begin
        data_valid = 1'b1; data_out = sram_mem[a];
      end else if (i == 1 || i == rc) begin
        data_valid = 1'($urandom); data_out = COLS'($urandom);
      end else begin
        data_valid = 1'b0; data_out = COLS'($urandom);
      end
    end
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; data_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if ({req_ready, rsp_valid, rsp_err, shift, serial_in, w_en, r_en} !== 7'b0 || addr !== '0 || rsp_rdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b addr=%0d rdata=%h, expected all 0",
               {req_ready, rsp_valid, rsp_err, shift, serial_in, w_en, r_en}, addr, rsp_rdata);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if ({req_ready, rsp_valid, rsp_err, shift, serial_in, w_en, r_en} !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_release: got %b, expected 1000000",
               {req_ready, rsp_valid, rsp_err, shift, serial_in, w_en, r_en});
    end
  endtask

  task automatic test_write();
    do_write(2'd1, 4'b1011, 1'b0);
    do_write(2'd0, 4'b0110, 1'b0);
  endtask

  task automatic test_read();
    do_write(2'd2, 4'hA, 1'b0);
    do_read(2'd2, 4, 1'b0);
    do_read(2'd1, 2, 1'b0);
  endtask

  task automatic test_timeout();
    do_write(2'd3, 4'h5, 1'b0);
    do_read(2'd3, TMO_EN ? 0 : 40, 1'b0);
    do_read(2'd3, TIMEOUT + 1, 1'b0);
  endtask

  task automatic test_spurious_idle();
    for (int i = 0; i < 4; i++) begin
      data_valid = 1'b1; data_out = COLS'($urandom);
      tick();
      tests_run++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL idle_spurious_dv%0d: got rsp_valid=%b req_ready=%b, expected 0/1", i, rsp_valid, req_ready);
      end
    end
    data_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(1, 0) == 1)
        do_write(ROWS'($urandom), COLS'($urandom), n != 9);
      else
        do_read(ROWS'($urandom), int'($urandom_range(8, 2)), n != 9);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [COLS-1:0] old;
    old = ref_mem[3];
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd3; req_wdata = ~old;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if ({req_ready, rsp_valid, rsp_err, shift, serial_in, w_en, r_en} !== 7'b0 || addr !== '0) begin
      tests_failed++;
      $display("FAIL shift_reset_outputs: got %b addr=%0d, expected all 0",
               {req_ready, rsp_valid, rsp_err, shift, serial_in, w_en, r_en}, addr);
    end
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      tests_run++;
      if ({req_ready, rsp_valid, rsp_err, shift, serial_in, w_en, r_en} !== 7'b1000000) begin
        tests_failed++;
        $display("FAIL shift_reset_after%0d: got %b, expected 1000000", i,
                 {req_ready, rsp_valid, rsp_err, shift, serial_in, w_en, r_en});
      end
    end
    do_read(2'd3, 3, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(1, 0) == 1)
        do_write(ROWS'($urandom), COLS'($urandom), 1'b0);
      else
        do_read(ROWS'($urandom), int'($urandom_range(9, 2)), 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 2**ROWS; i++) begin
      ref_mem[i]  = '0;
      sram_mem[i] = '0;
    end
    sram_sh = '0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_spurious_idle();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
